cmp_pipe_branch: RTL and testbench

- Parametrised, 2-stage pipelined magnitude comparator; successor to the fixed 32-bit combinational chunk comparator.
- Adds signed/unsigned mode, proper MSB-first priority reduction, RV32I branch-condition evaluation and a valid/ready handshake with a tag.
- Sits between operand fetch and PC-select logic in the branch unit of the pipelined core.

---
 rtl/cmp_pipe_branch.sv | 230 +++++++++++++++++++++++
 tb/tb_cmp_pipe_branch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe_branch.sv
// cmp_pipe_branch: two-stage pipelined magnitude comparator for the branch unit.
//
// Stage 1 splits the operands into WIDTH/CHUNK_W chunks and registers the
// per-chunk gt/eq/lt vectors. Stage 2 reduces those vectors MSB-first, then
// registers gt/eq/lt, the RV32I branch decision and the illegal-funct3 flag.
// Signed mode is used for funct3 = 10x (BLT/BGE). It works by inverting both
// MSBs so that an unsigned compare gives the signed ordering.
// WIDTH must be a multiple of CHUNK_W.
//
// Optional feature macro: CMP_PIPE_MINMAX_EN
//   When defined, the in_minmax and out_result ports are added. The pipeline
//   then also produces min (01) or max (10) of the operands in the selected
//   mode. The codes 00 and 11 give 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand beat handshake (in_ready = stage 1 can advance)
//   in_a, in_b            operands (rs1, rs2)
//   in_funct3             branch condition code
//   in_tag                opaque tag carried with the beat
//   in_minmax             (optional) min/max select
//   out_valid/out_ready   result handshake
//   out_gt/eq/lt          magnitude relation under the selected mode
//   out_taken             branch condition result
//   out_illegal           funct3 is 010 or 011
//   out_result            (optional) selected min/max value
//   out_tag               tag of the result
module cmp_pipe_branch #(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 2,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_funct3,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef CMP_PIPE_MINMAX_EN
  input  logic [1:0]         in_minmax,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_gt,
  output logic               out_eq,
  output logic               out_lt,
  output logic               out_taken,
  output logic               out_illegal,
`ifdef CMP_PIPE_MINMAX_EN
  output logic [WIDTH-1:0]   out_result,
`endif
  output logic [TAG_W-1:0]   out_tag
);

  localparam int N = WIDTH / CHUNK_W;

  // Handshake
  logic s1_valid_r;
  logic out_valid_r;
  logic s2_adv_s;
  logic s1_adv_s;

  // Stage 1 inputs, after the MSB flip for signed mode
  logic             signed_mode_s;
  logic [WIDTH-1:0] a_m_s;
  logic [WIDTH-1:0] b_m_s;
  logic [N-1:0]     chunk_gt_s;
  logic [N-1:0]     chunk_eq_s;
  logic [N-1:0]     chunk_lt_s;

  // Stage 1 registers
  logic [N-1:0]     s1_gt_r;
  logic [N-1:0]     s1_eq_r;
  logic [N-1:0]     s1_lt_r;
  logic [2:0]       s1_funct3_r;
  logic [TAG_W-1:0] s1_tag_r;

  // Stage 2 combinational results
  logic gt_s;
  logic eq_s;
  logic lt_s;
  logic eq_above_s;
  logic taken_s;
  logic illegal_s;

  // Stage 2 registers
  logic             out_gt_r;
  logic             out_eq_r;
  logic             out_lt_r;
  logic             out_taken_r;
  logic             out_illegal_r;
  logic [TAG_W-1:0] out_tag_r;

`ifdef CMP_PIPE_MINMAX_EN
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [1:0]       s1_minmax_r;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] out_result_r;
`endif

  // A stage moves when its downstream slot is empty or is draining this cycle.
  assign s2_adv_s = !out_valid_r || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  // When the MSBs are flipped, two's-complement order matches unsigned order.
  assign signed_mode_s = (in_funct3[2:1] == 2'b10);
  assign a_m_s = in_a ^ {signed_mode_s, {(WIDTH-1){1'b0}}};
  assign b_m_s = in_b ^ {signed_mode_s, {(WIDTH-1){1'b0}}};

  for (genvar g = 0; g < N; g++) begin : g_chunk
    assign chunk_gt_s[g] = (a_m_s[g*CHUNK_W +: CHUNK_W] >  b_m_s[g*CHUNK_W +: CHUNK_W]);
    assign chunk_eq_s[g] = (a_m_s[g*CHUNK_W +: CHUNK_W] == b_m_s[g*CHUNK_W +: CHUNK_W]);
    assign chunk_lt_s[g] = (a_m_s[g*CHUNK_W +: CHUNK_W] <  b_m_s[g*CHUNK_W +: CHUNK_W]);
  end

  // Stage 1 register: capture chunk compares on a handshake; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_gt_r     <= {N{1'b0}};
      s1_eq_r     <= {N{1'b0}};
      s1_lt_r     <= {N{1'b0}};
      s1_funct3_r <= 3'b000;
      s1_tag_r    <= {TAG_W{1'b0}};
`ifdef CMP_PIPE_MINMAX_EN
      s1_a_r      <= {WIDTH{1'b0}};
      s1_b_r      <= {WIDTH{1'b0}};
      s1_minmax_r <= 2'b00;
`endif
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_gt_r     <= chunk_gt_s;
        s1_eq_r     <= chunk_eq_s;
        s1_lt_r     <= chunk_lt_s;
        s1_funct3_r <= in_funct3;
        s1_tag_r    <= in_tag;
`ifdef CMP_PIPE_MINMAX_EN
        s1_a_r      <= in_a;
        s1_b_r      <= in_b;
        s1_minmax_r <= in_minmax;
`endif
      end
    end
  end

  // MSB-first reduction: a chunk decides only if every higher chunk is equal.
  always_comb begin
    gt_s       = 1'b0;
    lt_s       = 1'b0;
    eq_above_s = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      gt_s       = gt_s | (s1_gt_r[i] & eq_above_s);
      lt_s       = lt_s | (s1_lt_r[i] & eq_above_s);
      eq_above_s = eq_above_s & s1_eq_r[i];
    end
    eq_s = &s1_eq_r;
  end

  // Branch decision from funct3.
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (s1_funct3_r)
      3'b000:         taken_s = eq_s;
      3'b001:         taken_s = !eq_s;
      3'b100, 3'b110: taken_s = lt_s;
      3'b101, 3'b111: taken_s = !lt_s;
      3'b010, 3'b011: illegal_s = 1'b1;
      default:        taken_s = 1'b0;
    endcase
  end

`ifdef CMP_PIPE_MINMAX_EN
  // Min/max select. It reuses the reduction, so the mode matches the compare.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (s1_minmax_r)
      2'b01:   result_s = lt_s ? s1_a_r : s1_b_r;
      2'b10:   result_s = gt_s ? s1_a_r : s1_b_r;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end
`endif

  // Stage 2 register: the outputs stay frozen while out_valid && !out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_gt_r      <= 1'b0;
      out_eq_r      <= 1'b0;
      out_lt_r      <= 1'b0;
      out_taken_r   <= 1'b0;
      out_illegal_r <= 1'b0;
      out_tag_r     <= {TAG_W{1'b0}};
`ifdef CMP_PIPE_MINMAX_EN
      out_result_r  <= {WIDTH{1'b0}};
`endif
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_gt_r      <= gt_s;
        out_eq_r      <= eq_s;
        out_lt_r      <= lt_s;
        out_taken_r   <= taken_s;
        out_illegal_r <= illegal_s;
        out_tag_r     <= s1_tag_r;
`ifdef CMP_PIPE_MINMAX_EN
        out_result_r  <= result_s;
`endif
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_gt      = out_gt_r;
  assign out_eq      = out_eq_r;
  assign out_lt      = out_lt_r;
  assign out_taken   = out_taken_r;
  assign out_illegal = out_illegal_r;
  assign out_tag     = out_tag_r;
`ifdef CMP_PIPE_MINMAX_EN
  assign out_result  = out_result_r;
`endif

endmodule

// File: tb/tb_cmp_pipe_branch.sv
// Scoreboard bench for cmp_pipe_branch (WIDTH=32, CHUNK_W=2, TAG_W=5).
// The expected result of each accepted beat is computed from the branch rules
// and queued. A monitor pops and compares each accepted output.
module tb_cmp_pipe_branch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_funct3;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_gt;
  logic        out_eq;
  logic        out_lt;
  logic        out_taken;
  logic        out_illegal;
  logic [4:0]  out_tag;
`ifdef CMP_PIPE_MINMAX_EN
  logic [1:0]  in_minmax;
  logic [31:0] out_result;
`endif

  typedef struct packed {
    logic        gt;
    logic        eq;
    logic        lt;
    logic        taken;
    logic        illegal;
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic held = 1'b0;
  exp_t held_val;

  cmp_pipe_branch #(.WIDTH(32), .CHUNK_W(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct3(in_funct3), .in_tag(in_tag),
`ifdef CMP_PIPE_MINMAX_EN
    .in_minmax(in_minmax),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt),
    .out_taken(out_taken), .out_illegal(out_illegal),
`ifdef CMP_PIPE_MINMAX_EN
    .out_result(out_result),
`endif
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on whole operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input logic [4:0] tag,
                                 input logic [1:0] mm);
    exp_t e;
    bit   sm;
    sm        = (f3[2:1] == 2'b10);
    e.eq      = (a == b);
    e.lt      = sm ? ($signed(a) < $signed(b)) : (a < b);
    e.gt      = sm ? ($signed(a) > $signed(b)) : (a > b);
    e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
    case (f3)
      3'd0:       e.taken = e.eq;
      3'd1:       e.taken = !e.eq;
      3'd4, 3'd6: e.taken = e.lt;
      3'd5, 3'd7: e.taken = !e.lt;
      default:    e.taken = 1'b0;
    endcase
    e.tag = tag;
    e.res = 32'd0;
`ifdef CMP_PIPE_MINMAX_EN
    if (mm == 2'b01)      e.res = e.lt ? a : b;
    else if (mm == 2'b10) e.res = e.gt ? a : b;
    else                  e.res = 32'd0;
`else
    if (mm == 2'b11) e.res = 32'd0;
`endif
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.gt = out_gt; s.eq = out_eq; s.lt = out_lt;
    s.taken = out_taken; s.illegal = out_illegal; s.tag = out_tag;
`ifdef CMP_PIPE_MINMAX_EN
    s.res = out_result;
`else
    s.res = 32'd0;
`endif
    return s;
  endfunction

  // Output-ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor. At the negedge it looks at the handshakes of the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      held = 1'b0;
    end else begin
      if (held) chk("stall_stable", 64'(sample()), 64'(held_val));
      held     = out_valid && !out_ready;
      held_val = sample();
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_output", 64'(1), 64'(0));
        else chk("result", 64'(sample()), 64'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) begin
`ifdef CMP_PIPE_MINMAX_EN
        sb_q.push_back(model(in_a, in_b, in_funct3, in_tag, in_minmax));
`else
        sb_q.push_back(model(in_a, in_b, in_funct3, in_tag, 2'b00));
`endif
      end
    end
  end

  // Holds a beat until it is accepted. Returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [4:0] tag, input logic [1:0] mm);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_funct3 = f3; in_tag = tag;
`ifdef CMP_PIPE_MINMAX_EN
    in_minmax = mm;
`endif
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_funct3 = 3'($urandom); in_tag = 5'($urandom);
`ifdef CMP_PIPE_MINMAX_EN
    in_minmax = 2'($urandom);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 32'd0; in_b = 32'd0; in_funct3 = 3'd0; in_tag = 5'd0;
`ifdef CMP_PIPE_MINMAX_EN
    in_minmax = 2'd0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_outputs", 64'(sample()), 64'(0));

    // Latency and equality: out_valid rises one posedge after stage 1 captures.
    send(32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 5'd1, 2'b00);
    chk("latency_cycle1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("latency_cycle2", 64'(out_valid), 64'(1));
    send(32'hFFFFFFFF, 32'h00000001, 3'b100, 5'd2, 2'b00);
    send(32'hFFFFFFFF, 32'h00000001, 3'b110, 5'd3, 2'b00);
    send(32'h80000000, 32'h7FFFFFFF, 3'b111, 5'd4, 2'b00);
    send(32'h12345678, 32'h12345679, 3'b011, 5'd5, 2'b00);
    send(32'hFFFFFFF6, 32'h00000005, 3'b100, 5'd6, 2'b01);
    send(32'hFFFFFFF6, 32'h00000005, 3'b101, 5'd7, 2'b10);
    drain();

    // Backpressure: 4 back-to-back beats with out_ready held low for 3 cycles.
    rdy_mode = 2;
    fork
      begin
        for (int t = 1; t <= 4; t++)
          send($urandom, $urandom, 3'($urandom_range(0, 7)), 5'(t), 2'($urandom));
      end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("bp_first_valid", 64'(out_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        end
        rdy_mode = 0;
      end
    join
    drain();

    // Reset mid-stream drops in-flight beats.
    for (int t = 8; t < 11; t++) send($urandom, $urandom, 3'b001, 5'(t), 2'b00);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (4) @(negedge clk);
    chk("rst_no_output", 64'(out_valid), 64'(0));

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ (32'd1 << $urandom_range(0, 31));
          2:       b = {~a[31], a[30:0]};
          default: b = $urandom;
        endcase
        send(a, b, 3'($urandom_range(0, 7)), 5'($urandom), 2'($urandom));
      end
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
